// File: rtl/piso_serializer_ctrl_pkg.sv
// Shared types and constants for the two-requester PISO serializer controller.
//   state_t   : controller FSM states (idle / shifting a frame / inter-frame gap)
//   SRC_A/B   : encoding of the frame source on ser_src and in the grant pointer
//   cnt_width : width of the bit counter for an N-bit word
package piso_serializer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer_ctrl_if.sv
// Handshake and serial-stream bundle of the PISO serializer controller.
//   master : requester/sink side (drives a/b valid+data and ser_stall)
//   slave  : controller side (drives readys, serial outputs and busy)
interface piso_serializer_ctrl_if #(
  parameter int N = 4
);
  logic         a_valid;
  logic [N-1:0] a_data;
  logic         a_ready;
  logic         b_valid;
  logic [N-1:0] b_data;
  logic         b_ready;
  logic         ser_stall;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_first;
  logic         ser_last;
  logic         ser_src;
  logic         busy;

  modport master (
    output a_valid, a_data, b_valid, b_data, ser_stall,
    input  a_ready, b_ready, ser_out, ser_valid, ser_first, ser_last, ser_src, busy
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, ser_stall,
    output a_ready, b_ready, ser_out, ser_valid, ser_first, ser_last, ser_src, busy
  );
endinterface

// File: rtl/piso_shift_core.sv
// N-bit parallel-in serial-out shift register.
//   clk, rst : clock, asynchronous active-low clear
//   load     : capture din (has priority over shift_en)
//   shift_en : shift right by one with zero fill
//   din      : parallel word
//   bit0     : current LSB, i.e. the bit on the serial line
module piso_shift_core #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift_en,
  input  logic [N-1:0] din,
  output logic         bit0
);

  logic [N-1:0] sreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift_en) begin
      sreg <= {1'b0, sreg[N-1:1]};
    end
  end

  assign bit0 = sreg[0];

endmodule

// File: rtl/piso_serializer_ctrl.sv
// Two-requester serializer controller: round-robin arbitration between A and B,
// load of the winning word into the shift core, LSB-first framed serial output
// with stall support and an optional fixed inter-frame gap.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : handshake (a_*, b_*), sink stall and serial outputs, busy
// Parameters: N word width (>=2), GAP idle cycles after each frame (0..15).
module piso_serializer_ctrl #(
  parameter int N   = 4,
  parameter int GAP = 0
) (
  input logic                    clk,
  input logic                    rst,
  piso_serializer_ctrl_if.slave  bus
);
  import piso_serializer_ctrl_pkg::*;

  localparam int unsigned    CW       = cnt_width(N);
  localparam logic [CW-1:0]  LAST_IDX = CW'(N - 1);
  localparam logic [3:0]     GAP_LOAD = 4'((GAP > 0) ? GAP - 1 : 0);

  state_t        state, state_next;
  logic [CW-1:0] count;
  logic [3:0]    gap_cnt;
  logic          last_grant;
  logic          src;
  logic          grant_a, grant_b;
  logic          a_rdy, b_rdy, hs;
  logic          shift_en, last_bit, bit0, in_shift;

  // Tie goes to whoever was not granted last time.
  assign grant_a  = bus.a_valid && (!bus.b_valid || last_grant == SRC_B);
  assign grant_b  = bus.b_valid && (!bus.a_valid || last_grant == SRC_A);
  assign last_bit = (count == LAST_IDX);
  assign in_shift = (state == ST_SHIFT);
  assign hs       = a_rdy | b_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    a_rdy      = 1'b0;
    b_rdy      = 1'b0;
    shift_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        // Gated by rst so the readys also read 0 while reset is held.
        a_rdy = grant_a & rst;
        b_rdy = grant_b & rst;
        if (a_rdy || b_rdy) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (!bus.ser_stall) begin
          shift_en = 1'b1;
          if (last_bit) state_next = (GAP > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      gap_cnt    <= '0;
      last_grant <= SRC_B;
      src        <= SRC_A;
    end else begin
      if (hs) begin
        count      <= '0;
        last_grant <= b_rdy ? SRC_B : SRC_A;
        src        <= b_rdy ? SRC_B : SRC_A;
      end else if (shift_en) begin
        count <= last_bit ? '0 : count + 1'b1;
      end

      if (shift_en && last_bit) begin
        gap_cnt <= GAP_LOAD;
      end else if (state == ST_GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  piso_shift_core #(.N(N)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (hs),
    .shift_en (shift_en),
    .din      (b_rdy ? bus.b_data : bus.a_data),
    .bit0     (bit0)
  );

  assign bus.a_ready   = a_rdy;
  assign bus.b_ready   = b_rdy;
  assign bus.ser_valid = in_shift;
  assign bus.ser_out   = in_shift & bit0;
  assign bus.ser_first = in_shift & (count == '0);
  assign bus.ser_last  = in_shift & last_bit;
  assign bus.ser_src   = src;
  assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_piso_serializer_ctrl.sv
// Bench for piso_serializer_ctrl: two instances (GAP=0 and GAP=2) share the
// same stimulus. A beat-queue model predicts every output each cycle, and
// directed scenarios pin hand-computed values.
module tb_piso_serializer_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         a_valid = 1'b0, b_valid = 1'b0, ser_stall = 1'b0;
  logic [N-1:0] a_data = '0, b_data = '0;

  always #5 clk = ~clk;

  piso_serializer_ctrl_if #(.N(N)) bus0 ();
  piso_serializer_ctrl_if #(.N(N)) bus2 ();

  assign bus0.a_valid = a_valid;  assign bus2.a_valid = a_valid;
  assign bus0.a_data  = a_data;   assign bus2.a_data  = a_data;
  assign bus0.b_valid = b_valid;  assign bus2.b_valid = b_valid;
  assign bus0.b_data  = b_data;   assign bus2.b_data  = b_data;
  assign bus0.ser_stall = ser_stall;
  assign bus2.ser_stall = ser_stall;

  piso_serializer_ctrl #(.N(N), .GAP(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  piso_serializer_ctrl #(.N(N), .GAP(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  // {busy, a_ready, b_ready, ser_valid, ser_out, ser_first, ser_last, ser_src}
  logic [7:0] obs [2];
  assign obs[0] = {bus0.busy, bus0.a_ready, bus0.b_ready, bus0.ser_valid,
                   bus0.ser_out, bus0.ser_first, bus0.ser_last, bus0.ser_src};
  assign obs[1] = {bus2.busy, bus2.a_ready, bus2.b_ready, bus2.ser_valid,
                   bus2.ser_out, bus2.ser_first, bus2.ser_last, bus2.ser_src};

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // ---------------- model: per instance, a queue of expected output beats
  typedef struct packed {
    logic is_bit;
    logic val;
    logic first;
    logic last;
  } beat_t;

  beat_t       qb [2][64];
  int unsigned qh [2] = '{0, 0};
  int unsigned qn [2] = '{0, 0};
  logic        m_last_b [2] = '{1'b1, 1'b1};
  logic        m_src    [2] = '{1'b0, 1'b0};
  logic [7:0]  m_exp;
  logic        m_ga, m_gb;
  beat_t       m_hd;
  logic [N-1:0] m_word;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_ga = a_valid && (!b_valid || m_last_b[k]);
      m_gb = b_valid && (!a_valid || !m_last_b[k]);
      m_hd = qb[k][qh[k]];
      if (!rst)
        m_exp = '0;
      else if (qn[k] != 0)
        m_exp = {1'b1, 2'b00, m_hd.is_bit, m_hd.is_bit & m_hd.val,
                 m_hd.is_bit & m_hd.first, m_hd.is_bit & m_hd.last, m_src[k]};
      else
        m_exp = {1'b0, m_ga, m_gb, 4'b0000, m_src[k]};

      vectors++;
      if (obs[k] !== m_exp) begin
        miscompares++;
        $display("FAIL model_cmp dut_gap%0d t=%0t: got %b required %b", k * 2, $time, obs[k], m_exp);
      end

      // advance to the next cycle using the inputs the next edge will sample
      if (!rst) begin
        qn[k] = 0; qh[k] = 0; m_last_b[k] = 1'b1; m_src[k] = 1'b0;
      end else if (qn[k] != 0) begin
        if (!m_hd.is_bit || !ser_stall) begin
          qh[k] = (qh[k] + 1) % 64;
          qn[k] = qn[k] - 1;
        end
      end else if (m_ga || m_gb) begin
        m_last_b[k] = m_gb;
        m_src[k]    = m_gb;
        m_word      = m_gb ? b_data : a_data;
        for (int i = 0; i < N; i++) begin
          qb[k][(qh[k] + qn[k]) % 64] = '{1'b1, m_word[i], i == 0, i == N - 1};
          qn[k] = qn[k] + 1;
        end
        for (int g = 0; g < k * 2; g++) begin
          qb[k][(qh[k] + qn[k]) % 64] = '{1'b0, 1'b0, 1'b0, 1'b0};
          qn[k] = qn[k] + 1;
        end
      end
    end
  end

  // ---------------- directed checks
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    tick();
    while ((bus0.busy || bus2.busy) && n < 50) begin
      tick();
      n++;
    end
    if (bus0.busy || bus2.busy) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: busy still 1 after 50 cycles, required 0");
    end
  endtask

  logic [N-1:0] w;
  int           n;

  initial begin
    repeat (3) tick();
    rst = 1'b1;

    // 1) single A word 1011, GAP=0 timing
    wait_idle();
    w = 4'b1011; a_data = w; a_valid = 1'b1;
    @(negedge clk); check("t1_a_ready_t", bus0.a_ready, 1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 1) a_valid = 1'b0;
      if (i == 4) a_valid = 1'b1;
      @(negedge clk);
      if (i <= 4) begin
        check("t1_ser_out",   bus0.ser_out,   w[i-1]);
        check("t1_ser_valid", bus0.ser_valid, 1);
        check("t1_ser_first", bus0.ser_first, (i == 1));
        check("t1_ser_last",  bus0.ser_last,  (i == 4));
        check("t1_ser_src",   bus0.ser_src,   0);
        check("t1_no_ready",  bus0.a_ready,   0);
      end else begin
        check("t1_a_ready_t5", bus0.a_ready, 1);
      end
    end
    tick(); a_valid = 1'b0;

    // 2) both valid held: grants alternate A,B,A,B starting from reset pointer
    wait_idle();
    rst = 1'b0; tick(); rst = 1'b1;
    a_data = 4'h3; b_data = 4'hC; a_valid = 1'b1; b_valid = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 4; f++) begin
      n = 0;
      while (!(bus0.a_ready || bus0.b_ready) && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("t2_ready_prompt", n, 0);
      check("t2_grant", {bus0.a_ready, bus0.b_ready}, (f % 2) ? 2'b01 : 2'b10);
      w = (f % 2) ? 4'hC : 4'h3;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("t2_bit", bus0.ser_out, w[i]);
        check("t2_src", bus0.ser_src, f % 2);
      end
      @(negedge clk);
    end
    tick(); a_valid = 1'b0; b_valid = 1'b0;

    // 3) word 0110, stall on the second bit for 3 cycles
    wait_idle();
    a_data = 4'b0110; a_valid = 1'b1;
    @(negedge clk); check("t3_a_ready_t", bus0.a_ready, 1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      ser_stall = (i >= 2 && i <= 4);
      @(negedge clk);
      if (i <= 7) begin
        check("t3_ser_out",   bus0.ser_out,   (i >= 2 && i <= 6));
        check("t3_ser_valid", bus0.ser_valid, 1);
        check("t3_ser_last",  bus0.ser_last,  (i == 7));
        check("t3_no_ready",  {bus0.a_ready, bus0.b_ready}, 0);
      end else begin
        check("t3_a_ready_t8", bus0.a_ready, 1);
      end
    end
    tick(); a_valid = 1'b0; ser_stall = 1'b0;

    // 4) GAP=2 instance, B word F; stall during the gap is ignored
    wait_idle();
    b_data = 4'hF; b_valid = 1'b1;
    @(negedge clk); check("t4_b_ready_t", bus2.b_ready, 1);
    for (int i = 1; i <= 7; i++) begin
      tick();
      ser_stall = (i == 5 || i == 6);
      @(negedge clk);
      if (i <= 4) begin
        check("t4_ser_out",   bus2.ser_out,   1);
        check("t4_ser_valid", bus2.ser_valid, 1);
        check("t4_ser_src",   bus2.ser_src,   1);
      end else if (i <= 6) begin
        check("t4_gap_valid", bus2.ser_valid, 0);
        check("t4_gap_ready", {bus2.a_ready, bus2.b_ready}, 0);
        check("t4_gap_busy",  bus2.busy, 1);
      end else begin
        check("t4_b_ready_t7", bus2.b_ready, 1);
      end
    end
    tick(); b_valid = 1'b0; ser_stall = 1'b0;

    // 5) async reset mid-frame at the third bit of 1001
    wait_idle();
    a_data = 4'b1001; a_valid = 1'b1;
    @(negedge clk); check("t5_a_ready_t", bus0.a_ready, 1);
    tick(); a_valid = 1'b0;
    tick();
    tick(); #2;
    rst = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    #1;
    check("t5_rst_outs_gap0", obs[0], 0);
    check("t5_rst_outs_gap2", obs[1], 0);
    @(posedge clk); #4 rst = 1'b1;
    @(negedge clk);
    check("t5_grant_after_rst", {bus0.a_ready, bus0.b_ready}, 2'b10);
    w = 4'b1001;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 1) begin a_valid = 1'b0; b_valid = 1'b0; end
      @(negedge clk);
      check("t5_ser_out",   bus0.ser_out,   w[i-1]);
      check("t5_ser_first", bus0.ser_first, (i == 1));
      check("t5_ser_last",  bus0.ser_last,  (i == 4));
      check("t5_ser_src",   bus0.ser_src,   0);
    end

    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/piso_serializer_ctrl.md
# piso_serializer_ctrl

Two-requester serializer controller for the parallel-in serial-out shift register. It arbitrates N-bit words from two sources (A, B) with a round-robin grant, loads the winner into the shift register, and sequences the right-shift so that the word leaves LSB-first on a framed serial stream. The block sits between parallel producers and a single-bit link. It owns the load/shift sequencing, the bit count, the inter-frame gap and the downstream stall.

## Interface
Parameters:
- N, 4, word width in bits (≥2)
- GAP, 0, idle cycles forced after each frame (0..15)

Ports:
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-low reset (clears all state while low)
- a_valid  input  1  requester A has a word
- a_data  input  N  requester A word
- a_ready  output  1  A handshake accept
- b_valid  input  1  requester B has a word
- b_data  input  N  requester B word
- b_ready  output  1  B handshake accept
- ser_stall  input  1  sink back-pressure; freezes shifting
- ser_out  output  1  serial data bit
- ser_valid  output  1  ser_out carries a frame bit this cycle
- ser_first  output  1  first bit (word bit 0) of a frame
- ser_last  output  1  last bit (word bit N-1) of a frame
- ser_src  output  1  source of current frame (0 = A, 1 = B)
- busy  output  1  state ≠ IDLE

## Operation
- FSM states: IDLE, SHIFT, GAP.
- IDLE
  - a_ready/b_ready are combinational and go to the arbiter winner only; at most one is high.
  - Handshake = valid & ready.
  - On handshake: the shift register loads the winner's data, ser_src latches the winner, bit count ← 0, and the FSM moves to SHIFT.
- Arbitration
  - Only one valid: that requester wins.
  - Both valid: the requester not granted last time wins.
  - The last-grant pointer updates only on a handshake. Its reset value is B, so A wins the first tie.
- SHIFT
  - ser_valid = 1 and ser_out = shift_reg[0].
  - ser_first = (count == 0); ser_last = (count == N-1).
  - ser_stall = 0: the register shifts right with zero fill and count increments.
  - ser_stall = 1: the register and count hold, and the ser_* outputs remain valid with the same bit.
  - The last bit is consumed when count == N-1 and ser_stall = 0. The FSM then goes to GAP if GAP > 0, otherwise to IDLE.
- GAP
  - Lasts exactly GAP cycles; a gap counter is loaded with GAP-1 and counts down to 0.
  - ser_valid = 0, both ready signals = 0, ser_stall is ignored. Exits to IDLE.
- No ready signal is asserted outside IDLE. Requesters must hold valid and data stable until the handshake.
- Output values outside SHIFT:
  - ser_out = 0, ser_first = 0, ser_last = 0.
  - ser_src holds its last value.
- Reset (async, any state, including mid-frame): FSM ← IDLE, shift register ← 0, counts ← 0, pointer ← B, ser_src ← 0. All outputs read 0 while reset is asserted. A partial frame is discarded and is never resumed.

## Timing
- Handshake in cycle t → first bit in t+1 → last bit in t+N (no stall). Each stalled cycle adds one cycle.
- With GAP = 0, ready returns in t+N+1. Peak throughput is one word per N+1 cycles.
- With GAP = g, ready returns in t+N+1+g.
- Arbitration is a same-cycle combinational decision; the data load is registered.
- ser_stall is sampled at the clock edge and takes effect on the next state.

## Structure
- Shared package: FSM state enum (IDLE, SHIFT, GAP) and source encoding constants (SRC_A = 0, SRC_B = 1).
- Sub-module `piso_shift_core`:
  - N-bit register with load, shift-enable and async active-low clear.
  - Right shift with zero fill; exposes bit 0.
  - Instantiated once.
- The controller holds the FSM, arbiter pointer, bit counter (clog2(N) bits, no wrap beyond N-1) and gap counter (4 bits).

## Test plan
- N = 4, GAP = 0, a_valid with a_data = 4'b1011 at t:
  - a_ready high at t; ser_out = 1,1,0,1 at t+1..t+4.
  - ser_first at t+1, ser_last at t+4, ser_src = 0.
  - a_ready available again at t+5.
- Both valid held continuously, a_data = 4'h3, b_data = 4'hC:
  - Grants alternate A, B, A, B.
  - Frames are 1,1,0,0 then 0,0,1,1.
  - ser_src toggles per frame.
- Frame 4'b0110, ser_stall high at the second bit for 3 cycles:
  - ser_out holds 1 with ser_valid = 1 for 4 cycles total.
  - ser_last shifts to t+7.
  - No ready signal during the frame.
- GAP = 2, b_data = 4'hF:
  - Four 1-bits, then 2 cycles with ser_valid = 0 and both readys low.
  - b_ready returns at t+7.
- rst driven low asynchronously between clock edges at the third bit of 4'b1001:
  - All outputs go to 0 immediately.
  - After release, a_valid = 1 and b_valid = 1 produce an A grant (pointer back at B).
  - The new frame is emitted cleanly.
